reg_bank_nxw: RTL and testbench

Parametrised, clocked successor to the 8-bit D-latch register. It generalises the block into a DEPTH x WIDTH register bank with:
- a gated synchronous write port
- two independent combinational read ports with write-through bypass
- per-word valid tracking
- a registered occupancy count

It is the general-purpose storage element for datapath assignments that previously instantiated fixed-width latches.

---
 rtl/reg_bank_nxw_if.sv | 30 +++
 rtl/reg_bank_nxw.sv | 79 +++++++
 tb/tb_reg_bank_nxw.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bank_nxw_if.sv
// Bus bundle for reg_bank_nxw: gated write port, two read ports, status.
// The master drives requests; the slave (the bank) returns read data and status.
interface reg_bank_nxw_if #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 3
);
   logic              enable;
   logic              clr;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [WIDTH-1:0]  wdata;
   logic [ADDR_W-1:0] raddr_a;
   logic [WIDTH-1:0]  rdata_a;
   logic              rvalid_a;
   logic [ADDR_W-1:0] raddr_b;
   logic [WIDTH-1:0]  rdata_b;
   logic              rvalid_b;
   logic [ADDR_W:0]   occupancy;
   logic              wr_err;

   modport master (
      output enable, clr, we, waddr, wdata, raddr_a, raddr_b,
      input  rdata_a, rvalid_a, rdata_b, rvalid_b, occupancy, wr_err
   );

   modport slave (
      input  enable, clr, we, waddr, wdata, raddr_a, raddr_b,
      output rdata_a, rvalid_a, rdata_b, rvalid_b, occupancy, wr_err
   );
endinterface

// File: rtl/reg_bank_nxw.sv
// DEPTH x WIDTH register bank: gated synchronous write, two combinational
// write-through read ports, per-word valid bits and a registered occupancy count.
module reg_bank_nxw #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input logic          clk,
   input logic          rst,
   reg_bank_nxw_if.slave bus
);

   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [DEPTH-1:0]  valid;
   logic [ADDR_W:0]   occ;
   logic              err;

   logic              waddr_ok;
   logic              wr_req;
   logic              wr_ok;
   logic              clr_now;

   assign waddr_ok = ({1'b0, bus.waddr} < DEPTH_W);
   assign clr_now  = bus.enable && bus.clr;
   assign wr_req   = bus.enable && !bus.clr && bus.we;
   assign wr_ok    = wr_req && waddr_ok;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         valid <= '0;
         occ   <= '0;
         err   <= 1'b0;
      end else if (clr_now) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         valid <= '0;
         occ   <= '0;
         err   <= 1'b0;
      end else if (wr_req) begin
         if (waddr_ok) begin
            mem[bus.waddr]   <= bus.wdata;
            valid[bus.waddr] <= 1'b1;
            // only a first write to a word grows the count, so it never exceeds DEPTH
            if (!valid[bus.waddr]) occ <= occ + ONE_W;
            err <= 1'b0;
         end else begin
            err <= 1'b1;
         end
      end
   end

   logic [ADDR_W-1:0] raddr [2];
   logic [WIDTH:0]    rd    [2];

   assign raddr[0] = bus.raddr_a;
   assign raddr[1] = bus.raddr_b;

   // {valid, data}; the pending write or clear is visible in the same cycle
   for (genvar p = 0; p < 2; p++) begin : g_rd
      always_comb begin
         rd[p] = '0;
         if (rst && ({1'b0, raddr[p]} < DEPTH_W) && !clr_now) begin
            if (wr_ok && (bus.waddr == raddr[p])) rd[p] = {1'b1, bus.wdata};
            else                                   rd[p] = {valid[raddr[p]], mem[raddr[p]]};
         end
      end
   end

   assign bus.rdata_a   = rd[0][WIDTH-1:0];
   assign bus.rvalid_a  = rd[0][WIDTH];
   assign bus.rdata_b   = rd[1][WIDTH-1:0];
   assign bus.rvalid_b  = rd[1][WIDTH];
   assign bus.occupancy = occ;
   assign bus.wr_err    = err;

endmodule

// File: tb/tb_reg_bank_nxw.sv
// Bench for reg_bank_nxw: a DEPTH=8 and a DEPTH=6 instance share one stimulus
// stream and are compared against an array model, plus directed vectors.
module tb_reg_bank_nxw;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable, clr, we;
   logic [2:0] waddr, raddr_a, raddr_b;
   logic [7:0] wdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reg_bank_nxw_if #(.WIDTH(8), .ADDR_W(3)) if8 ();
   reg_bank_nxw_if #(.WIDTH(8), .ADDR_W(3)) if6 ();

   assign if8.enable  = enable;
   assign if8.clr     = clr;
   assign if8.we      = we;
   assign if8.waddr   = waddr;
   assign if8.wdata   = wdata;
   assign if8.raddr_a = raddr_a;
   assign if8.raddr_b = raddr_b;
   assign if6.enable  = enable;
   assign if6.clr     = clr;
   assign if6.we      = we;
   assign if6.waddr   = waddr;
   assign if6.wdata   = wdata;
   assign if6.raddr_a = raddr_a;
   assign if6.raddr_b = raddr_b;

   reg_bank_nxw #(.WIDTH(8), .DEPTH(8), .ADDR_W(3)) dut8 (.clk(clk), .rst(rst), .bus(if8));
   reg_bank_nxw #(.WIDTH(8), .DEPTH(6), .ADDR_W(3)) dut6 (.clk(clk), .rst(rst), .bus(if6));

   // reference model: plain arrays, one bank per instance
   int         dep [2] = '{8, 6};
   logic [7:0] m_mem [2][8];
   logic       m_val [2][8];
   logic       m_err [2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 8; i++) begin
            m_mem[d][i] = 8'h00;
            m_val[d][i] = 1'b0;
         end
         m_err[d] = 1'b0;
      end
   endtask

   task automatic model_update();
      for (int d = 0; d < 2; d++) begin
         if (!enable) continue;
         if (clr) begin
            for (int i = 0; i < 8; i++) begin
               m_mem[d][i] = 8'h00;
               m_val[d][i] = 1'b0;
            end
            m_err[d] = 1'b0;
         end else if (we) begin
            if (int'(waddr) < dep[d]) begin
               m_mem[d][waddr] = wdata;
               m_val[d][waddr] = 1'b1;
               m_err[d] = 1'b0;
            end else begin
               m_err[d] = 1'b1;
            end
         end
      end
   endtask

   function automatic logic [8:0] exp_rd(input int d, input logic [2:0] ra);
      if (!rst || int'(ra) >= dep[d] || (enable && clr)) return 9'h000;
      if (enable && we && waddr == ra) return {1'b1, wdata};
      return {m_val[d][ra], m_mem[d][ra]};
   endfunction

   function automatic int exp_occ(input int d);
      int n = 0;
      for (int i = 0; i < 8; i++) n += int'(m_val[d][i]);
      return n;
   endfunction

   task automatic check_model(input string tag);
      logic [8:0] ea, eb;
      logic [8:0] aa, ab;
      logic [3:0] ao;
      logic       ae;
      for (int d = 0; d < 2; d++) begin
         ea = exp_rd(d, raddr_a);
         eb = exp_rd(d, raddr_b);
         aa = (d == 0) ? {if8.rvalid_a, if8.rdata_a} : {if6.rvalid_a, if6.rdata_a};
         ab = (d == 0) ? {if8.rvalid_b, if8.rdata_b} : {if6.rvalid_b, if6.rdata_b};
         ao = (d == 0) ? if8.occupancy : if6.occupancy;
         ae = (d == 0) ? if8.wr_err : if6.wr_err;
         chk($sformatf("%s d%0d port_a", tag, d), 32'(aa), 32'(ea));
         chk($sformatf("%s d%0d port_b", tag, d), 32'(ab), 32'(eb));
         chk($sformatf("%s d%0d occupancy", tag, d), 32'(ao), 32'(exp_occ(d)));
         chk($sformatf("%s d%0d wr_err", tag, d), 32'(ae), 32'(rst ? m_err[d] : 1'b0));
      end
   endtask

   // one clock cycle, entered and left 1ns after a rising edge
   task automatic step(input logic r, input logic e, input logic c, input logic w,
                       input logic [2:0] wa, input logic [7:0] wd,
                       input logic [2:0] ra, input logic [2:0] rb, input string tag);
      rst = r; enable = e; clr = c; we = w; waddr = wa; wdata = wd;
      raddr_a = ra; raddr_b = rb;
      if (!r) model_reset();
      #1;
      check_model({tag, " pre"});
      @(posedge clk);
      if (rst) model_update();
      #1;
      check_model({tag, " post"});
   endtask

   typedef struct {
      logic       en, cl, w;
      logic [2:0] wa;
      logic [7:0] wd;
      logic [2:0] ra, rb;
      logic [3:0] occ;
      logic [7:0] da;
      logic       va;
      logic [7:0] db;
      logic       vb;
      logic       err;
   } vec_t;

   vec_t vecs [12];

   initial begin
      // expectations for the DEPTH=8 bank, read back after the edge with we/clr dropped
      vecs[0]  = '{1'b1, 1'b0, 1'b1, 3'd3, 8'hA5, 3'd3, 3'd7, 4'd1, 8'hA5, 1'b1, 8'h00, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 1'b1, 3'd7, 8'h3C, 3'd3, 3'd7, 4'd2, 8'hA5, 1'b1, 8'h3C, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 1'b1, 3'd3, 8'hFF, 3'd3, 3'd7, 4'd2, 8'hFF, 1'b1, 8'h3C, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 3'd3, 8'h11, 3'd3, 3'd7, 4'd2, 8'hFF, 1'b1, 8'h3C, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 1'b1, 3'd0, 8'h10, 3'd0, 3'd3, 4'd3, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 1'b1, 3'd1, 8'h11, 3'd1, 3'd0, 4'd4, 8'h11, 1'b1, 8'h10, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 1'b1, 3'd2, 8'h12, 3'd2, 3'd1, 4'd5, 8'h12, 1'b1, 8'h11, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 1'b1, 3'd4, 8'h14, 3'd4, 3'd2, 4'd6, 8'h14, 1'b1, 8'h12, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 1'b1, 3'd5, 8'h15, 3'd5, 3'd4, 4'd7, 8'h15, 1'b1, 8'h14, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 1'b1, 3'd6, 8'h16, 3'd6, 3'd7, 4'd8, 8'h16, 1'b1, 8'h3C, 1'b1, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 1'b1, 3'd0, 8'h11, 3'd0, 3'd7, 4'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd3, 3'd6, 4'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

      rst = 1'b0; enable = 1'b0; clr = 1'b0; we = 1'b0;
      waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
      model_reset();

      // reset, then idle reads of every address
      repeat (2) @(posedge clk);
      #1;
      chk("rst occ8", 32'(if8.occupancy), 0);
      chk("rst err8", 32'(if8.wr_err), 0);
      rst = 1'b1; enable = 1'b1;
      for (int a = 0; a < 8; a++) begin
         raddr_a = 3'(a);
         raddr_b = 3'(7 - a);
         #1;
         chk($sformatf("idle a%0d", a), 32'({if8.rvalid_a, if8.rdata_a}), 0);
         chk($sformatf("idle b%0d", a), 32'({if8.rvalid_b, if8.rdata_b}), 0);
         check_model("idle");
      end
      @(posedge clk);
      #1;

      // write/rewrite, hold, fill, clear-over-write
      for (int v = 0; v < 12; v++) begin
         enable = vecs[v].en; clr = vecs[v].cl; we = vecs[v].w;
         waddr = vecs[v].wa; wdata = vecs[v].wd;
         raddr_a = vecs[v].ra; raddr_b = vecs[v].rb;
         #1;
         check_model($sformatf("vec%0d pre", v));
         @(posedge clk);
         model_update();
         #1;
         we = 1'b0; clr = 1'b0; enable = 1'b1;
         #1;
         chk($sformatf("vec%0d occ", v), 32'(if8.occupancy), 32'(vecs[v].occ));
         chk($sformatf("vec%0d a", v), 32'({if8.rvalid_a, if8.rdata_a}), 32'({vecs[v].va, vecs[v].da}));
         chk($sformatf("vec%0d b", v), 32'({if8.rvalid_b, if8.rdata_b}), 32'({vecs[v].vb, vecs[v].db}));
         chk($sformatf("vec%0d err", v), 32'(if8.wr_err), 32'(vecs[v].err));
         check_model($sformatf("vec%0d post", v));
      end
      for (int a = 0; a < 8; a++) begin
         raddr_a = 3'(a);
         #1;
         chk($sformatf("cleared a%0d", a), 32'({if8.rvalid_a, if8.rdata_a}), 0);
      end

      // bypass, then the same write with enable low must neither bypass nor store
      @(posedge clk);
      #1;
      enable = 1'b1; we = 1'b1; waddr = 3'd2; wdata = 8'h5A; raddr_a = 3'd2; raddr_b = 3'd5;
      #1;
      chk("bypass data", 32'(if8.rdata_a), 32'h5A);
      chk("bypass valid", 32'(if8.rvalid_a), 1);
      check_model("bypass pre");
      @(posedge clk);
      model_update();
      #1;
      enable = 1'b0; wdata = 8'h77;
      #1;
      chk("hold no-bypass", 32'({if8.rvalid_a, if8.rdata_a}), 32'h15A);
      @(posedge clk);
      #1;
      chk("hold stored", 32'({if8.rvalid_a, if8.rdata_a}), 32'h15A);
      check_model("hold post");

      // out-of-range on the DEPTH=6 bank
      step(1'b1, 1'b1, 1'b0, 1'b1, 3'd6, 8'hEE, 3'd6, 3'd2, "oor wr");
      chk("oor err6", 32'(if6.wr_err), 1);
      chk("oor occ6", 32'(if6.occupancy), 1);
      step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd7, 3'd7, "oor rd");
      chk("oor rd7", 32'({if6.rvalid_a, if6.rdata_a}), 0);
      chk("oor err hold", 32'(if6.wr_err), 1);
      step(1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 8'h21, 3'd1, 3'd7, "oor ok");
      chk("oor err clr", 32'(if6.wr_err), 0);
      chk("oor occ6 2", 32'(if6.occupancy), 2);

      // asynchronous reset between edges during a write
      @(negedge clk);
      enable = 1'b1; clr = 1'b0; we = 1'b1; waddr = 3'd4; wdata = 8'h99;
      raddr_a = 3'd1; raddr_b = 3'd4;
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      chk("arst occ8", 32'(if8.occupancy), 0);
      chk("arst occ6", 32'(if6.occupancy), 0);
      chk("arst a8", 32'({if8.rvalid_a, if8.rdata_a}), 0);
      chk("arst b8", 32'({if8.rvalid_b, if8.rdata_b}), 0);
      @(posedge clk);
      #1;
      check_model("arst held");
      @(negedge clk);
      rst = 1'b1; we = 1'b0;
      @(posedge clk);
      #1;
      step(1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 8'h42, 3'd1, 3'd4, "arst rel");
      chk("arst rel occ8", 32'(if8.occupancy), 1);
      chk("arst rel occ6", 32'(if6.occupancy), 1);

      // randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         logic       r, e, c, w;
         logic [2:0] wa, ra, rb;
         r  = ($urandom_range(0, 49) != 0);
         e  = ($urandom_range(0, 7) != 0);
         c  = ($urandom_range(0, 15) == 0);
         w  = $urandom_range(0, 1) == 1;
         wa = 3'($urandom_range(0, 7));
         ra = $urandom_range(0, 1) == 1 ? wa : 3'($urandom_range(0, 7));
         rb = $urandom_range(0, 1) == 1 ? wa : 3'($urandom_range(0, 7));
         step(r, e, c, w, wa, 8'($urandom), ra, rb, $sformatf("rnd%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
